// File: rtl/kbd_pkg.sv
// Shared types and defaults for the key-event scheduler.
package kbd_pkg;

  // One key event as it moves through the queue.
  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } kbd_event_t;

  // Scheduler FSM: IDLE pops the next event, HOLD paces the emitted one.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } sched_state_t;

  localparam int DEFAULT_HOLD_CYCLES = 400000;
  localparam int DEFAULT_FIFO_DEPTH  = 8;
  localparam int DEFAULT_CNT_W       = 20;

endpackage

// File: rtl/kbd_event_fifo.sv
// Show-ahead synchronous FIFO of key events. Full/empty come from the
// registered count, so a push while full is refused even if a pop happens
// in the same cycle.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  kbd_event_t             din,
  output kbd_event_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kbd_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_sched.sv
// Merges live PS/2 key events and injected (autotype) events into one queue
// and replays them to the keyboard matrix as a toggle-strobe stream, holding
// each event for HOLD_CYCLES so the Z80 scan routine sees it.
//
// Injection handshake: inj_ready is combinational; an event transfers in a
// cycle where inj_valid && inj_ready. The source may hold inj_valid and its
// data across refused cycles; nothing is taken until ready is seen high.
module kbd_event_sched
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_strobe,
  input  logic       ps2_pressed,
  input  logic       ps2_extended,
  input  logic [7:0] ps2_code,
  input  logic       inj_valid,
  output logic       inj_ready,
  input  logic       inj_pressed,
  input  logic       inj_extended,
  input  logic [7:0] inj_code,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       busy,
  output logic       overflow
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic             strobe_prev;
  logic             ps2_evt;
  logic             inj_fire;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             load_out;
  logic             cnt_dec;
  kbd_event_t       push_event;
  kbd_event_t       head;

  // Edge detector history; loading it in reset too avoids a phantom event.
  always_ff @(posedge clk) begin
    strobe_prev <= ps2_strobe;
  end

  // PS/2 has strict priority: an injected event is refused in a PS/2 cycle.
  assign ps2_evt    = (ps2_strobe != strobe_prev);
  assign inj_ready  = !fifo_full && !ps2_evt;
  assign inj_fire   = inj_valid && inj_ready;
  assign fifo_push  = ps2_evt || inj_fire;
  assign push_event = ps2_evt ? kbd_event_t'{ps2_pressed, ps2_extended, ps2_code}
                              : kbd_event_t'{inj_pressed, inj_extended, inj_code};

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_event),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky drop flag: a PS/2 event arriving on a full queue is lost.
  always_ff @(posedge clk) begin
    if (reset)                      overflow <= 1'b0;
    else if (ps2_evt && fifo_full)  overflow <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next state: leave IDLE on any queued event, leave HOLD when the count expires.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_next = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: pop and load together, count down only while holding.
  always_comb begin
    fifo_pop = 1'b0;
    load_out = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        fifo_pop = !fifo_empty;
        load_out = !fifo_empty;
      end
      S_HOLD:  cnt_dec = (hold_cnt != '0);
      default: ;
    endcase
  end

  // Hold counter: loaded on emission, runs down to zero during HOLD.
  always_ff @(posedge clk) begin
    if (reset)         hold_cnt <= '0;
    else if (load_out) hold_cnt <= HOLD_LOAD;
    else if (cnt_dec)  hold_cnt <= hold_cnt - 1'b1;
  end

  // Output registers: event fields and strobe change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= 8'h00;
    end else if (load_out) begin
      key_strobe   <= ~key_strobe;
      key_pressed  <= head.pressed;
      key_extended <= head.extended;
      key_code     <= head.code;
    end
  end

  assign busy = (state == S_HOLD) || (fifo_count != '0);

endmodule

// File: tb/tb_kbd_event_sched.sv
// Self-checking bench for kbd_event_sched with HOLD_CYCLES=4, FIFO_DEPTH=4.
module tb_kbd_event_sched;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       ps2_strobe = 1'b0;
  logic       ps2_pressed = 1'b0;
  logic       ps2_extended = 1'b0;
  logic [7:0] ps2_code = 8'h00;
  logic       inj_valid = 1'b0;
  logic       inj_ready;
  logic       inj_pressed = 1'b0;
  logic       inj_extended = 1'b0;
  logic [7:0] inj_code = 8'h00;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       busy;
  logic       overflow;

  kbd_event_sched #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_strobe   (ps2_strobe),
    .ps2_pressed  (ps2_pressed),
    .ps2_extended (ps2_extended),
    .ps2_code     (ps2_code),
    .inj_valid    (inj_valid),
    .inj_ready    (inj_ready),
    .inj_pressed  (inj_pressed),
    .inj_extended (inj_extended),
    .inj_code     (inj_code),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .busy         (busy),
    .overflow     (overflow)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Queue of pending events plus the earliest cycle the next emission may happen.
  logic [9:0] m_q[$];
  logic [9:0] exp_q[$];
  logic       m_prev = 1'b0;
  int         m_next_pop = 0;
  int         m_cyc = 0;
  logic       m_ovf = 1'b0;
  logic [9:0] m_key = '0;
  logic       m_popped = 1'b0;
  logic       m_rst_seen = 1'b1;

  logic [9:0] log_evt[$];
  int         log_cyc[$];

  always @(posedge clk) begin
    logic       evt;
    logic       was_full;
    logic [9:0] e;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_prev     = ps2_strobe;
      m_next_pop = 0;
      m_ovf      = 1'b0;
      m_key      = '0;
      m_popped   = 1'b0;
      m_rst_seen = 1'b1;
    end else begin
      evt      = (ps2_strobe != m_prev);
      was_full = (m_q.size() == DEPTH);
      m_popped = 1'b0;
      if (m_cyc >= m_next_pop && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_key = e;
        m_next_pop = m_cyc + HOLD + 1;
        m_popped = 1'b1;
        exp_q.push_back(e);
      end
      if (evt) begin
        if (was_full) m_ovf = 1'b1;
        else          m_q.push_back({ps2_pressed, ps2_extended, ps2_code});
      end else if (inj_valid && !was_full) begin
        m_q.push_back({inj_pressed, inj_extended, inj_code});
      end
      m_prev     = ps2_strobe;
      m_rst_seen = 1'b0;
    end
    m_cyc++;
  end

  // ---------------- scoreboard monitor ----------------
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    logic       tog;
    logic [9:0] got;
    logic [9:0] e;
    got = {key_pressed, key_extended, key_code};
    if (m_rst_seen) begin
      mon_prev = key_strobe;
    end else begin
      tog = (key_strobe != mon_prev);
      total++;
      if (tog !== m_popped) begin
        bad++;
        $display("FAIL strobe_timing cyc=%0d toggled=%0b expected=%0b", m_cyc, tog, m_popped);
      end
      if (tog) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL emit_unexpected cyc=%0d got=%h expected=none", m_cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL emit_data cyc=%0d got=%h expected=%h", m_cyc, got, e);
          end
        end
        log_evt.push_back(got);
        log_cyc.push_back(m_cyc);
      end
      total++;
      if (got !== m_key) begin
        bad++;
        $display("FAIL key_hold cyc=%0d got=%h expected=%h", m_cyc, got, m_key);
      end
      mon_prev = key_strobe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2_send(input logic [9:0] ev);
    {ps2_pressed, ps2_extended, ps2_code} = ev;
    ps2_strobe = ~ps2_strobe;
  endtask

  task automatic wait_idle(input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
      tick();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL idle_timeout busy=%0b expected=0 after %0d cycles", busy, limit);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ps2_strobe = 1'b1;
    inj_valid  = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({key_strobe, busy, overflow} !== 3'b000) begin
        bad++;
        $display("FAIL reset_flags strobe/busy/ovf=%b expected=000", {key_strobe, busy, overflow});
      end
      total++;
      if ({key_pressed, key_extended, key_code} !== 10'h000) begin
        bad++;
        $display("FAIL reset_key got=%h expected=000", {key_pressed, key_extended, key_code});
      end
      tick();
    end
  endtask

  task automatic test_single();
    ps2_send(10'h21C);
    @(negedge clk);
    total++;
    if (inj_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_ready got=%0b expected=0", inj_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if ({key_strobe, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_pre strobe/busy=%b expected=01", {key_strobe, busy});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({key_strobe, key_pressed, key_extended, key_code} !== 11'h61C) begin
        bad++;
        $display("FAIL single_out i=%0d got=%h expected=61c", i,
                 {key_strobe, key_pressed, key_extended, key_code});
      end
      total++;
      if (busy !== (i < 4)) begin
        bad++;
        $display("FAIL single_busy i=%0d got=%0b expected=%0b", i, busy, (i < 4));
      end
      tick();
    end
  endtask

  task automatic test_inject();
    logic [9:0] evs[3];
    int idx = 0;
    int last_acc = -1;
    int n0 = log_evt.size();
    evs[0] = 10'h21C;
    evs[1] = 10'h01C;
    evs[2] = 10'h232;
    for (int cy = 0; cy < 30; cy++) begin
      inj_valid = (idx < 3);
      if (idx < 3) {inj_pressed, inj_extended, inj_code} = evs[idx];
      @(negedge clk);
      if (inj_valid && inj_ready) begin
        idx++;
        last_acc = cy;
      end
      tick();
    end
    inj_valid = 1'b0;
    wait_idle(100);
    total++;
    if (last_acc != 2 || idx != 3) begin
      bad++;
      $display("FAIL inject_accept accepted=%0d last_cycle=%0d expected=3/2", idx, last_acc);
    end
    total++;
    if (log_evt.size() - n0 != 3) begin
      bad++;
      $display("FAIL inject_count got=%0d expected=3", log_evt.size() - n0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (log_evt[n0 + k] !== evs[k]) begin
          bad++;
          $display("FAIL inject_order k=%0d got=%h expected=%h", k, log_evt[n0 + k], evs[k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (log_cyc[n0 + k + 1] - log_cyc[n0 + k] != HOLD + 1) begin
          bad++;
          $display("FAIL inject_spacing k=%0d got=%0d expected=%0d", k,
                   log_cyc[n0 + k + 1] - log_cyc[n0 + k], HOLD + 1);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int n0 = log_evt.size();
    ps2_send(10'h245);
    inj_valid = 1'b1;
    {inj_pressed, inj_extended, inj_code} = 10'h316;
    @(negedge clk);
    total++;
    if (inj_ready !== 1'b0) begin
      bad++;
      $display("FAIL conflict_ready0 got=%0b expected=0", inj_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if (inj_ready !== 1'b1) begin
      bad++;
      $display("FAIL conflict_ready1 got=%0b expected=1", inj_ready);
    end
    tick();
    inj_valid = 1'b0;
    wait_idle(100);
    total++;
    if (log_evt.size() - n0 != 2 || log_evt[n0] !== 10'h245 || log_evt[n0 + 1] !== 10'h316) begin
      bad++;
      $display("FAIL conflict_order count=%0d first=%h second=%h expected=2/245/316",
               log_evt.size() - n0, (log_evt.size() > n0) ? log_evt[n0] : 10'h3FF,
               (log_evt.size() > n0 + 1) ? log_evt[n0 + 1] : 10'h3FF);
    end
  endtask

  task automatic test_overflow();
    int n0 = log_evt.size();
    for (int k = 1; k <= 6; k++) begin
      ps2_send({2'b10, 8'(k)});
      tick();
    end
    @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set got=%0b expected=1", overflow);
    end
    tick();
    wait_idle(200);
    total++;
    if (log_evt.size() - n0 != 5) begin
      bad++;
      $display("FAIL overflow_count got=%0d expected=5", log_evt.size() - n0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (log_evt[n0 + k] !== {2'b10, 8'(k + 1)}) begin
          bad++;
          $display("FAIL overflow_seq k=%0d got=%h expected=%h", k, log_evt[n0 + k], {2'b10, 8'(k + 1)});
        end
      end
    end
    @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky got=%0b expected=1", overflow);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int n1;
    ps2_send(10'h211);
    tick();
    ps2_send(10'h212);
    tick();
    ps2_send(10'h213);
    tick();
    @(negedge clk);
    total++;
    if ({busy, key_code} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL midrst_pre busy/code=%h expected=111", {busy, key_code});
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n1 = log_evt.size();
    @(negedge clk);
    total++;
    if ({key_strobe, key_pressed, key_extended, key_code, busy, overflow} !== 13'h0) begin
      bad++;
      $display("FAIL midrst_out got=%h expected=0000",
               {key_strobe, key_pressed, key_extended, key_code, busy, overflow});
    end
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (log_evt.size() != n1 || key_strobe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet toggles=%0d strobe=%0b busy=%0b expected=0/0/0",
               log_evt.size() - n1, key_strobe, busy);
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    logic exp_busy;
    logic acc;
    inj_valid = 1'b0;
    for (int cy = 0; cy < 400; cy++) begin
      if ($urandom_range(0, 5) == 0) ps2_send(10'($urandom));
      if (!inj_valid && $urandom_range(0, 2) == 0) begin
        inj_valid = 1'b1;
        {inj_pressed, inj_extended, inj_code} = 10'($urandom);
      end
      @(negedge clk);
      exp_ready = (m_q.size() != DEPTH) && (ps2_strobe == m_prev);
      exp_busy  = (m_cyc < m_next_pop) || (m_q.size() != 0);
      total++;
      if (inj_ready !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d got=%0b expected=%0b", cy, inj_ready, exp_ready);
      end
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL rand_busy cyc=%0d got=%0b expected=%0b", cy, busy, exp_busy);
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++;
        $display("FAIL rand_overflow cyc=%0d got=%0b expected=%0b", cy, overflow, m_ovf);
      end
      acc = inj_valid && inj_ready;
      tick();
      if (acc) inj_valid = 1'b0;
    end
    inj_valid = 1'b0;
    wait_idle(200);
    total++;
    if (exp_q.size() != 0 || m_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain pending=%0d expected=0", exp_q.size() + m_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    wait_idle(50);
    test_inject();
    test_conflict();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit reached", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
